// File: rtl/regfile_writeback_queue.sv
// Write-side front end of the register file: arbitrates ALU/load results into an
// in-order FIFO and drains one entry per cycle onto the register file write port.
// Also answers "is a write to register R still in flight?" for decode stalls.
module regfile_writeback_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_dest,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_dest,
    input  logic [XLEN-1:0]          ld_data,
    input  logic                     wb_hold,
    output logic [4:0]               wb_dest,
    output logic                     wb_write_enable,
    output logic [XLEN-1:0]          wb_data,
    input  logic [4:0]               query_reg,
    output logic                     query_pending,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      dest_mem_q [DEPTH];
    logic [4:0]      dest_mem_d [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_dest_q, wb_dest_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            push;
    logic            pop;
    logic [4:0]      push_dest;
    logic [XLEN-1:0] push_data;

    assign full            = (count_q == CW'(DEPTH));
    assign empty           = (count_q == '0);
    assign count           = count_q;
    // Readiness looks only at registered occupancy: no pass-through on a same-cycle pop.
    assign ld_ready        = !full;
    assign alu_ready       = !full && !ld_valid;
    assign wb_write_enable = wb_we_q;
    assign wb_dest         = wb_dest_q;
    assign wb_data         = wb_data_q;

    // Select the winning producer; x0 results complete the handshake but are dropped.
    always_comb begin
        push_dest = ld_valid ? ld_dest : alu_dest;
        push_data = ld_valid ? ld_data : alu_data;
        push      = !full && (ld_valid || alu_valid) && (push_dest != 5'd0);
        pop       = !empty && !wb_hold;
    end

    // Next-state for pointers, occupancy, storage and the write-port stage.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        dest_mem_d = dest_mem_q;
        data_mem_d = data_mem_q;
        wb_we_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        if (push) begin
            dest_mem_d[wr_ptr_q] = push_dest;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            wb_we_d   = 1'b1;
            wb_dest_d = dest_mem_q[rd_ptr_q];
            wb_data_d = data_mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pending-write lookup over occupied entries plus the write currently on the port.
    always_comb begin
        query_pending = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (dest_mem_q[rd_ptr_q + PW'(i)] == query_reg)) begin
                query_pending = 1'b1;
            end
        end
        if (wb_we_q && (wb_dest_q == query_reg)) begin
            query_pending = 1'b1;
        end
        if (query_reg == 5'd0) begin
            query_pending = 1'b0;
        end
    end

    // Control state; reset discards queued entries and suppresses any write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wb_we_q   <= wb_we_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        dest_mem_q <= dest_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed vector table, hand-written corner
// sequences and constrained-random traffic checked against a queue-based model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, alu_ready, ld_valid, ld_ready, wb_hold;
    logic [4:0]      alu_dest, ld_dest, wb_dest, query_reg;
    logic [XLEN-1:0] alu_data, ld_data, wb_data;
    logic            wb_write_enable, query_pending, full, empty;
    logic [2:0]      count;

    regfile_writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .wb_hold(wb_hold), .wb_dest(wb_dest), .wb_write_enable(wb_write_enable),
        .wb_data(wb_data), .query_reg(query_reg), .query_pending(query_pending),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    typedef struct {
        logic        av;  logic [4:0] ad;  logic [31:0] adat;
        logic        lv;  logic [4:0] ldd; logic [31:0] ldat;
        logic        hold; logic [4:0] qr;
        logic        e_ar; logic e_lr; logic [2:0] e_cnt;
        logic        e_we; logic [4:0] e_wd; logic [31:0] e_wdat; logic e_qp;
    } vec_t;

    // Reference model: queue of pending writes plus the write-port register.
    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_wd;
    logic [31:0] m_wv;
    bit          last_la, last_aa;
    logic [36:0] wlog[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        bit m_full, m_pend;
        m_full = (q.size() == DEPTH);
        m_pend = 1'b0;
        foreach (q[i]) if (q[i].d == query_reg) m_pend = 1'b1;
        if (m_we && m_wd == query_reg) m_pend = 1'b1;
        if (query_reg == 5'd0) m_pend = 1'b0;
        chk("ld_ready", ld_ready, !m_full);
        chk("alu_ready", alu_ready, !m_full && !ld_valid);
        chk("count", count, q.size());
        chk("full", full, m_full);
        chk("empty", empty, q.size() == 0);
        chk("wb_write_enable", wb_write_enable, m_we);
        chk("wb_dest", wb_dest, m_wd);
        chk("wb_data", wb_data, m_wv);
        chk("query_pending", query_pending, m_pend);
    endtask

    // Advance one clock edge, updating the model from the inputs present at that edge.
    task automatic tick();
        bit pop, la, aa;
        ent_t e;
        pop = (q.size() != 0) && !wb_hold;
        la  = ld_valid && (q.size() < DEPTH);
        aa  = alu_valid && (q.size() < DEPTH) && !ld_valid;
        @(posedge clk);
        if (pop) begin
            m_we = 1'b1; m_wd = q[0].d; m_wv = q[0].v;
            q.delete(0);
        end else begin
            m_we = 1'b0;
        end
        if (la && ld_dest != 5'd0) begin
            e.d = ld_dest; e.v = ld_data; q.push_back(e);
        end else if (aa && alu_dest != 5'd0) begin
            e.d = alu_dest; e.v = alu_data; q.push_back(e);
        end
        last_la = la;
        last_aa = aa;
        #1;
        if (wb_write_enable) wlog.push_back({wb_dest, wb_data});
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0;
        alu_dest = '0; alu_data = '0; ld_dest = '0; ld_data = '0;
    endtask

    vec_t vec[8];

    initial begin
        vec[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 32'h0,        0};
        vec[1] = '{0, 0, 32'h0,        0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 32'h0,        1};
        vec[2] = '{0, 0, 32'h0,        0, 0, 0, 0, 5, 1, 1, 0, 1, 5, 32'hDEADBEEF, 1};
        vec[3] = '{1, 4, 32'h44,       1, 3, 32'h33, 0, 5, 0, 1, 0, 0, 5, 32'hDEADBEEF, 0};
        vec[4] = '{1, 4, 32'h44,       0, 0, 0, 0, 3, 1, 1, 1, 0, 5, 32'hDEADBEEF, 1};
        vec[5] = '{0, 0, 32'h0,        0, 0, 0, 0, 4, 1, 1, 1, 1, 3, 32'h33,       1};
        vec[6] = '{1, 0, 32'h1234,     0, 0, 0, 0, 0, 1, 1, 0, 1, 4, 32'h44,       0};
        vec[7] = '{0, 0, 32'h0,        0, 0, 0, 0, 4, 1, 1, 0, 0, 4, 32'h44,       0};

        m_we = 1'b0; m_wd = '0; m_wv = '0;
        reset = 1'b1; wb_hold = 1'b0; query_reg = '0;
        idle();
        #12;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_we", wb_write_enable, 0);
        chk("rst_dest", wb_dest, 0);
        chk("rst_data", wb_data, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table: single write latency, contention, x0 drop.
        for (int i = 0; i < 8; i++) begin
            alu_valid = vec[i].av; alu_dest = vec[i].ad; alu_data = vec[i].adat;
            ld_valid = vec[i].lv; ld_dest = vec[i].ldd; ld_data = vec[i].ldat;
            wb_hold = vec[i].hold; query_reg = vec[i].qr;
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vec[i].e_ar);
            chk($sformatf("v%0d_ld_ready", i), ld_ready, vec[i].e_lr);
            chk($sformatf("v%0d_count", i), count, vec[i].e_cnt);
            chk($sformatf("v%0d_we", i), wb_write_enable, vec[i].e_we);
            chk($sformatf("v%0d_dest", i), wb_dest, vec[i].e_wd);
            chk($sformatf("v%0d_data", i), wb_data, vec[i].e_wdat);
            chk($sformatf("v%0d_qpend", i), query_pending, vec[i].e_qp);
            tick();
        end

        // Fill with hold, offer a fifth, release; three rounds wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            idle(); wb_hold = 1'b0;
            for (int k = 0; k < 2; k++) begin #1; check_model(); tick(); end
            wb_hold = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                ld_valid = 1'b1; ld_dest = 5'(k); ld_data = 32'(r * 16 + k);
                query_reg = 5'(k); #1; check_model(); tick();
            end
            ld_dest = 5'd5; ld_data = 32'(r * 16 + 5);
            #1;
            chk("fill_full", full, 1);
            chk("fill_ld_ready", ld_ready, 0);
            check_model(); tick();
            wb_hold = 1'b0;
            wlog.delete();
            for (int k = 0; k < 10; k++) begin
                #1; check_model(); tick();
                if (last_la) ld_valid = 1'b0;
            end
            chk("wrap_nwrites", wlog.size(), 5);
            for (int k = 0; k < 5 && k < wlog.size(); k++)
                chk($sformatf("wrap%0d_order%0d", r, k), wlog[k], {5'(k + 1), 32'(r * 16 + k + 1)});
        end

        // Same destination twice: both written in order.
        idle(); query_reg = 5'd7; wlog.delete();
        alu_valid = 1'b1; alu_dest = 5'd7; alu_data = 32'h1;
        #1; check_model(); tick();
        alu_data = 32'h2;
        #1; check_model(); tick();
        idle();
        for (int k = 0; k < 4; k++) begin #1; check_model(); tick(); end
        chk("samedest_npulse", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("samedest_first", wlog[0], {5'd7, 32'h1});
            chk("samedest_last", wlog[1], {5'd7, 32'h2});
        end

        // Reset mid-run with three entries queued.
        wb_hold = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            ld_valid = 1'b1; ld_dest = 5'(k + 8); ld_data = 32'(k);
            #1; check_model(); tick();
        end
        idle(); query_reg = 5'd9;
        chk("pre_rst_count", count, 3);
        reset = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_we", wb_write_enable, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_qpend", query_pending, 0);
        q.delete(); m_we = 1'b0; m_wd = '0; m_wv = '0;
        #2; reset = 1'b0; wb_hold = 1'b0; wlog.delete();
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin #1; check_model(); tick(); end
        chk("post_rst_nwrites", wlog.size(), 0);

        // Random traffic honouring the hold-until-ready handshake.
        idle();
        for (int c = 0; c < 600; c++) begin
            if (!alu_valid && $urandom_range(0, 1) == 1) begin
                alu_valid = 1'b1; alu_dest = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!ld_valid && $urandom_range(0, 2) == 0) begin
                ld_valid = 1'b1; ld_dest = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            wb_hold   = ($urandom_range(0, 4) == 0);
            query_reg = 5'($urandom_range(0, 7));
            #1; check_model(); tick();
            if (last_aa) alu_valid = 1'b0;
            if (last_la) ld_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side front end of the register file controller: collects results from the ALU and the load unit, serialises them through an in-order FIFO, and drives the single register-file write port (dest / write_enable / data_in). It also exposes a pending-write query, so decode can stall on destinations whose write has not yet landed. It sits between execute/memory and the register file controller.

## Interface
- XLEN, 32, data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_dest  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted this cycle
- ld_dest  in  5  load destination register
- ld_data  in  XLEN  load result
- wb_hold  in  1  freeze draining (debug halt)
- wb_dest  out  5  to register file dest
- wb_write_enable  out  1  to register file write_enable
- wb_data  out  XLEN  to register file data_in
- query_reg  in  5  register index checked by decode
- query_pending  out  1  write to query_reg still in flight
- count  out  $clog2(DEPTH)+1  occupied FIFO entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Handshake: a producer holds valid/dest/data stable until it sees ready=1 in the same cycle. A transfer occurs on the edge where valid&ready.
- Arbitration: at most one push per cycle; load has priority.
  - ld_ready = !full
  - alu_ready = !full & !ld_valid
- Readiness depends only on current full, never on a same-cycle pop (no pass-through).
- x0 filtering: an accepted producer with dest==0 completes the handshake but is not enqueued; count is unchanged.
- Pop:
  - Every edge with !empty & !wb_hold, the head entry is popped.
  - On that edge the output stage loads wb_dest/wb_data from the popped entry and wb_write_enable=1.
  - Otherwise wb_write_enable=0 and wb_dest/wb_data hold their last values.
- Simultaneous push and pop: count unchanged; allowed at any occupancy except that a push is impossible when full.
- Ordering: strict FIFO. Two entries with the same dest are both written, in acceptance order.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count disambiguates full/empty.
- query_pending (combinational) is 1 iff query_reg≠0 and either:
  - any occupied FIFO entry has dest==query_reg, or
  - wb_write_enable=1 and wb_dest==query_reg.
- query_reg==0 always gives 0.

## Timing
- Reset (asynchronous, immediate): pointers 0, count 0, empty 1, full 0, wb_write_enable 0, wb_dest 0, wb_data 0. FIFO contents are don't-care.
- Reset mid-operation discards all queued entries; no write_enable pulse follows.
- Latency, with wb_hold=0 and the queue empty:
  - accept on edge N
  - entry popped on edge N+1; wb outputs valid during cycle N+1..N+2
  - register file samples on edge N+2
- Throughput: one write per cycle sustained.
- wb_hold=1: no pop, wb_write_enable=0 from the next edge. Pushes continue until full.
- alu_ready/ld_ready/full/empty/count/query_pending are functions of current registered state plus same-cycle inputs only (ld_valid, query_reg). There are no combinational paths from wb_hold.

## Test plan
- Single ALU write: alu_valid=1, dest=5, data=0xDEADBEEF at edge N → wb_write_enable=1, wb_dest=5, wb_data=0xDEADBEEF during cycle after edge N+1. query_pending(5)=1 from after edge N until after edge N+2.
- Contention: ld_valid and alu_valid both 1 (ld dest=3, alu dest=4) → ld accepted first, alu_ready=0 that cycle. Writes appear as 3 then 4 on consecutive cycles.
- x0 drop: ALU dest=0, data=0x1234 → handshake completes, count stays 0, no wb_write_enable pulse, query_pending(0)=0.
- Fill/wrap: wb_hold=1, push 4 loads (dest 1..4) → full=1, ld_ready=0. A fifth offer is held. Release wb_hold → writes 1,2,3,4, then the held fifth, in order. Repeat 3 times to exercise pointer wrap.
- Same-dest ordering: push dest=7 data=0x1 then dest=7 data=0x2 → two pulses, the last wb_data=0x2. query_pending(7) stays 1 until the second write's edge.
- Reset mid-run: 3 entries queued, assert reset asynchronously → count=0, wb_write_enable=0 immediately. After release, no stale writes appear.
